cisc_mem_responder: RTL and testbench

- Memory-side responder for the accumulator CPU's control unit. Services the CPU's rd/wr strobes on a single shared instruction/data memory.
- Word format is op[7:5] plus operand address[4:0].
- Before the CPU is released it runs a boot phase: a byte-stream loader fills memory from address 0 through a valid/ready handshake. It then asserts cpu_run, which the top level uses as the CPU's reset release.

---
 rtl/cisc_mem_responder.sv | 56 +++++
 tb/tb_cisc_mem_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cisc_mem_responder.sv
// cisc_mem_responder: boot loader plus zero-latency shared instruction/data memory for the accumulator CPU
module cisc_mem_responder #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int PROT_TOP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_valid,
  input  logic [DW-1:0] boot_data,
  input  logic          boot_last,
  output logic          boot_ready,
  output logic          cpu_run,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          err_prot,
  output logic          err_conflict
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam logic [AW:0] PT = (AW+1)'(PROT_TOP);
  state_t state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [2**AW];
  logic boot_acc, run_wr, prot;
  assign boot_ready = state == BOOT;
  assign boot_acc = boot_valid && boot_ready;
  assign run_wr = state == RUN && wr && !rd;
  assign prot = {1'b0, addr} < PT;
  assign dout = (state == RUN && rd && !wr) ? mem[addr] : '0;
  // memory write port: loader bytes in BOOT, unprotected exclusive CPU writes in RUN; contents survive reset
  always_ff @(posedge clk)
    if (boot_acc) mem[ptr] <= boot_data;
    else if (run_wr && !prot) mem[addr] <= din;
  // boot sequencer and sticky error flags; pointer holds at the top so a full-depth load never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      ptr <= '0;
      cpu_run <= 1'b0;
      err_prot <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      if (boot_acc) begin
        ptr <= &ptr ? ptr : ptr + 1'b1;
        if (boot_last || &ptr) begin
          state <= RUN;
          cpu_run <= 1'b1;
        end
      end
      if (state == RUN && rd && wr) err_conflict <= 1'b1;
      if (run_wr && prot) err_prot <= 1'b1;
    end
endmodule

// File: tb/tb_cisc_mem_responder.sv
// tb_cisc_mem_responder: directed scoreboard bench for the boot loader and CPU memory port
module tb_cisc_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic boot_valid = 1'b0, boot_last = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0] boot_data = '0, din = '0, dout;
  logic [4:0] addr = '0;
  logic boot_ready, cpu_run, err_prot, err_conflict;
  logic [7:0] m [32];
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  cisc_mem_responder #(.AW(5), .DW(8), .PROT_TOP(16)) dut (
    .clk(clk), .rst_n(rst_n), .boot_valid(boot_valid), .boot_data(boot_data),
    .boot_last(boot_last), .boot_ready(boot_ready), .cpu_run(cpu_run),
    .addr(addr), .rd(rd), .wr(wr), .din(din), .dout(dout),
    .err_prot(err_prot), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_boot(input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    boot_valid = v; boot_data = d; boot_last = l;
  endtask

  task automatic do_read(input logic [4:0] a, input string tag);
    @(negedge clk);
    boot_valid = 1'b0; wr = 1'b0; rd = 1'b1; addr = a;
    exp_q.push_back(m[a]);
    #1 chk(tag, dout, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    boot_valid = 1'b0; rd = 1'b0; wr = 1'b1; addr = a; din = d;
    if (a >= 5'd16) m[a] = d;
  endtask

  task automatic idle();
    @(negedge clk);
    boot_valid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b4 [4];
    b4[0] = 8'hA1; b4[1] = 8'h42; b4[2] = 8'h63; b4[3] = 8'hE0;
    #2;
    chk("rst_boot_ready", 8'(boot_ready), 8'd1);
    chk("rst_cpu_run", 8'(cpu_run), 8'd0);
    chk("rst_err_prot", 8'(err_prot), 8'd0);
    chk("rst_err_conflict", 8'(err_conflict), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd = 1'b1; addr = 5'd0;
    #1 chk("boot_dout_zero", dout, 8'd0);
    for (int i = 0; i < 4; i++) begin
      drive_boot(1'b1, b4[i], i == 3);
      m[i] = b4[i];
      #1 chk("boot4_run_low", 8'(cpu_run), 8'd0);
    end
    idle();
    #1 chk("boot4_cpu_run", 8'(cpu_run), 8'd1);
    chk("boot4_ready_low", 8'(boot_ready), 8'd0);
    for (int i = 0; i < 4; i++) do_read(5'(i), "boot4_read");

    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_boot(1'b1, 8'(i * 7 + 3), 1'b0);
      m[i] = 8'(i * 7 + 3);
      #1 chk("full_run_low", 8'(cpu_run), 8'd0);
    end
    drive_boot(1'b1, 8'h77, 1'b0);
    #1 chk("full_cpu_run", 8'(cpu_run), 8'd1);
    chk("full_33_not_ready", 8'(boot_ready), 8'd0);
    do_read(5'd0, "full_addr0_kept");
    do_read(5'd31, "full_addr31");
    do_read(5'd16, "full_addr16");

    chk("prot_flag_clear", 8'(err_prot), 8'd0);
    do_write(5'd20, 8'h5A);
    do_read(5'd20, "wr20_read");
    chk("wr20_no_prot", 8'(err_prot), 8'd0);
    do_write(5'd3, 8'hFF);
    idle();
    #1 chk("prot_flag_set", 8'(err_prot), 8'd1);
    do_read(5'd3, "prot_addr3_kept");

    chk("conf_flag_clear", 8'(err_conflict), 8'd0);
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 5'd7; din = 8'h11;
    #1 chk("conf_dout_zero", dout, 8'd0);
    do_read(5'd7, "conf_addr7_kept");
    chk("conf_flag_set", 8'(err_conflict), 8'd1);
    do_write(5'd25, 8'hC3);
    do_read(5'd25, "wr25_read");
    chk("conf_flag_sticky", 8'(err_conflict), 8'd1);
    chk("prot_flag_sticky", 8'(err_prot), 8'd1);

    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_cpu_run", 8'(cpu_run), 8'd0);
    chk("async_boot_ready", 8'(boot_ready), 8'd1);
    chk("async_err_prot", 8'(err_prot), 8'd0);
    chk("async_err_conflict", 8'(err_conflict), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_boot(1'b1, 8'h99, 1'b1);
    m[0] = 8'h99;
    idle();
    #1 chk("reboot_cpu_run", 8'(cpu_run), 8'd1);
    for (int i = 0; i < 4; i++) do_read(5'(i), "reboot_read");
    do_read(5'd20, "reboot_addr20");

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_boot(1'b0, 8'hEE, 1'b1);
      drive_boot(1'b0, 8'hDD, 1'b0);
      #1 chk("gap_run_low", 8'(cpu_run), 8'd0);
      drive_boot(1'b1, 8'(8'h30 + i), i == 3);
      m[i] = 8'(8'h30 + i);
    end
    idle();
    #1 chk("gap_cpu_run", 8'(cpu_run), 8'd1);
    for (int i = 0; i < 5; i++) do_read(5'(i), "gap_read");
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
